loop_group_scheduler: RTL

Time-multiplexes the multi-group loop-nest controller between up to NUM_GROUPS independently programmed loop groups. It tracks which groups hold a pending loop nest and picks the next group round-robin, skipping groups whose downstream is stalled. It drives the controller's active group id, start, stall and block_done, and preempts a running group after a configurable quantum so stalled or long groups do not starve others. It sits between the instruction decoder / group-config path and the loop controller.

---
 rtl/loop_group_scheduler_pkg.sv | 16 +
 rtl/loop_group_scheduler_rr_arbiter.sv | 29 ++
 rtl/loop_group_scheduler.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/loop_group_scheduler_pkg.sv
// Shared types and defaults for the loop-group scheduler.
// Holds the scheduler FSM encoding and the default group-id width and preemption quantum.
package loop_group_scheduler_pkg;

   localparam int unsigned DefGroupIdW = 2;
   localparam int unsigned DefQuantum  = 64;

   typedef enum logic [2:0] {
      StIdle,
      StSelect,
      StRun,
      StSwitch,
      StFinish
   } sched_state_e;

endpackage

// File: rtl/loop_group_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester found searching upward from last+1 (wrapping).
// The caller registers the grant.
module loop_group_scheduler_rr_arbiter #(
   parameter int unsigned IdW = 2,
   parameter int unsigned N   = 1 << IdW
) (
   input  logic [N-1:0]   req,
   input  logic [IdW-1:0] last,
   output logic [IdW-1:0] grant,
   output logic           grant_v
);

   logic [IdW-1:0] idx;

   // Walk from the farthest offset down so the nearest requester after 'last' wins.
   always_comb begin
      grant   = last;
      grant_v = 1'b0;
      idx     = '0;
      for (int k = int'(N); k >= 1; k--) begin
         idx = IdW'((int'(last) + k) % int'(N));
         if (req[idx]) begin
            grant   = idx;
            grant_v = 1'b1;
         end
      end
   end

endmodule

// File: rtl/loop_group_scheduler.sv
// Time-multiplexes the loop controller between pending loop groups, round-robin,
// skipping stalled groups and preempting a running group after QUANTUM productive cycles.
module loop_group_scheduler
   import loop_group_scheduler_pkg::*;
#(
   parameter int unsigned GROUP_ID_W = DefGroupIdW,
   parameter int unsigned NUM_GROUPS = 1 << GROUP_ID_W,
   parameter int unsigned QUANTUM_W  = 8,
   parameter int unsigned QUANTUM    = DefQuantum
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cfg_group_v,
   input  logic [GROUP_ID_W-1:0] cfg_group_id,
   input  logic                  sched_start,
   input  logic [NUM_GROUPS-1:0] grp_stall,
   output logic                  sched_busy,
   output logic                  sched_done,
   output logic                  ctrl_start,
   output logic [GROUP_ID_W-1:0] ctrl_loop_group_id,
   output logic                  ctrl_stall,
   input  logic                  ctrl_done,
   output logic                  ctrl_block_done,
   output logic [NUM_GROUPS-1:0] pending
);

   localparam logic [QUANTUM_W-1:0] QuantumVal = QUANTUM_W'(QUANTUM);

   sched_state_e          state_q, state_d;
   logic [NUM_GROUPS-1:0] pending_q, pending_d;
   logic [GROUP_ID_W-1:0] last_grant_q, last_grant_d;
   logic [GROUP_ID_W-1:0] id_q, id_d;
   logic [QUANTUM_W-1:0]  cnt_q, cnt_d;
   logic                  first_launch_q, first_launch_d;
   logic                  ctrl_start_q, ctrl_start_d;

   logic [NUM_GROUPS-1:0] eligible, active_mask, set_mask, clear_mask;
   logic [GROUP_ID_W-1:0] grant;
   logic                  grant_v;
   logic                  stall_raw;

   assign eligible    = pending_q & ~grp_stall;
   assign active_mask = NUM_GROUPS'(1) << id_q;
   assign set_mask    = cfg_group_v ? (NUM_GROUPS'(1) << cfg_group_id) : '0;

   loop_group_scheduler_rr_arbiter #(
      .IdW (GROUP_ID_W),
      .N   (NUM_GROUPS)
   ) u_rr_arbiter (
      .req     (eligible),
      .last    (last_grant_q),
      .grant   (grant),
      .grant_v (grant_v)
   );

   always_comb begin
      state_d         = state_q;
      last_grant_d    = last_grant_q;
      id_d            = id_q;
      cnt_d           = cnt_q;
      first_launch_d  = first_launch_q;
      ctrl_start_d    = 1'b0;
      clear_mask      = '0;
      stall_raw       = 1'b1;
      sched_busy      = 1'b0;
      sched_done      = 1'b0;
      ctrl_block_done = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (sched_start) begin
               if (pending_q != '0) begin
                  state_d        = StSelect;
                  first_launch_d = 1'b1;
               end else begin
                  state_d = StFinish;
               end
            end
         end
         StSelect: begin
            sched_busy = 1'b1;
            if (grant_v) begin
               id_d           = grant;
               last_grant_d   = grant;
               cnt_d          = '0;
               ctrl_start_d   = first_launch_q;
               first_launch_d = 1'b0;
               state_d        = StRun;
            end
         end
         StRun: begin
            sched_busy = 1'b1;
            stall_raw  = grp_stall[id_q];
            if (!stall_raw && (cnt_q != QuantumVal)) begin
               cnt_d = cnt_q + QUANTUM_W'(1);
            end
            // A cfg for the finishing group in the same cycle keeps it pending.
            if (ctrl_done) begin
               clear_mask = active_mask;
               if (((pending_q & ~active_mask) | set_mask) != '0) begin
                  state_d = StSelect;
               end else begin
                  state_d = StFinish;
               end
            end else if ((QUANTUM != 0) && (cnt_q == QuantumVal) &&
                         ((eligible & ~active_mask) != '0)) begin
               state_d = StSwitch;
            end
         end
         StSwitch: begin
            sched_busy = 1'b1;
            state_d    = StSelect;
         end
         StFinish: begin
            sched_done      = 1'b1;
            ctrl_block_done = 1'b1;
            state_d         = StIdle;
         end
         default: state_d = StIdle;
      endcase

      pending_d = (pending_q & ~clear_mask) | set_mask;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         pending_q      <= '0;
         last_grant_q   <= GROUP_ID_W'(NUM_GROUPS - 1);
         id_q           <= '0;
         cnt_q          <= '0;
         first_launch_q <= 1'b0;
         ctrl_start_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         last_grant_q   <= last_grant_d;
         id_q           <= id_d;
         cnt_q          <= cnt_d;
         first_launch_q <= first_launch_d;
         ctrl_start_q   <= ctrl_start_d;
      end
   end

   assign pending            = pending_q;
   assign ctrl_loop_group_id = id_q;
   assign ctrl_start         = ctrl_start_q;
   // Stall is forced low while reset is held so every output reads zero.
   assign ctrl_stall         = reset & stall_raw;

endmodule
